// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: synchronises the HUB75 pins, shifts in column data, and replays each latched row as a valid/ready pixel stream.
// Optional FM6126 register-write decoding is enabled by defining HUB75_RX_FM6126_EN.
module hub75_rx #(
  parameter int WIDTH = 64,
  parameter int ADDR_W = 5,
  localparam int XW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        hub_rgb0,
  input  logic [2:0]        hub_rgb1,
  input  logic [ADDR_W-1:0] hub_addr,
  input  logic              hub_blank,
  input  logic              hub_latch,
  input  logic              hub_sclk,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [XW-1:0]     pix_x,
  output logic [ADDR_W-1:0] pix_row,
  output logic [2:0]        pix_rgb0,
  output logic [2:0]        pix_rgb1,
  output logic              row_done,
  output logic              overrun,
  output logic              col_err,
  output logic              panel_on
`ifdef HUB75_RX_FM6126_EN
  ,
  output logic [15:0]       fm_r1,
  output logic [15:0]       fm_r2,
  output logic [1:0]        fm_wr
`endif
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int SW = 6 + ADDR_W + 3;
  // The blank bit resets high so panel_on stays low until a real level arrives.
  localparam logic [SW-1:0] SYNC_RST = SW'(4);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  logic [SW-1:0]     s1_q, s2_q;
  logic              sclk_s3_q, latch_s3_q;
  logic [ADDR_W-1:0] addr_s3_q;
  logic [5:0]        rgb_s2;
  logic              sclk_rise, latch_rise, latch_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= SYNC_RST;
      s2_q       <= SYNC_RST;
      sclk_s3_q  <= 1'b0;
      latch_s3_q <= 1'b0;
      addr_s3_q  <= '0;
    end else begin
      s1_q       <= {hub_rgb0, hub_rgb1, hub_addr, hub_blank, hub_latch, hub_sclk};
      s2_q       <= s1_q;
      sclk_s3_q  <= s2_q[0];
      latch_s3_q <= s2_q[1];
      addr_s3_q  <= s2_q[3 +: ADDR_W];
    end
  end

  assign rgb_s2     = s2_q[SW-1 -: 6];
  assign sclk_rise  = s2_q[0] & ~sclk_s3_q;
  assign latch_rise = s2_q[1] & ~latch_s3_q;
  assign latch_fall = ~s2_q[1] & latch_s3_q;

  // Newest column enters at the top so index 0 always holds the oldest one.
  logic [5:0] sr_q   [WIDTH];
  logic [5:0] hold_q [WIDTH];
  logic       commit_q;
  state_t     state_q;
  logic       hold_take;

  assign hold_take = commit_q && (state_q == S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_col
      if (gi == WIDTH - 1) begin : g_tail
        always_ff @(posedge clk or posedge reset) begin
          if (reset)          sr_q[gi] <= '0;
          else if (sclk_rise) sr_q[gi] <= rgb_s2;
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge reset) begin
          if (reset)          sr_q[gi] <= '0;
          else if (sclk_rise) sr_q[gi] <= sr_q[gi+1];
        end
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          hold_q[gi] <= '0;
        else if (hold_take) hold_q[gi] <= sr_q[gi];
      end
    end
  endgenerate

  logic [CW-1:0] col_cnt_q;
  logic [6:0]    lat_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      if (latch_fall)
        col_cnt_q <= '0;
      else if (sclk_rise && col_cnt_q != CW'(WIDTH + 1))
        col_cnt_q <= col_cnt_q + CW'(1);
      if (latch_rise)
        lat_cnt_q <= '0;
      else if (sclk_rise && s2_q[1] && lat_cnt_q != 7'h7F)
        lat_cnt_q <= lat_cnt_q + 7'd1;
    end
  end

  // Classify the latch fall: row commit, register write or length error.
  logic       row_ok, bad_len;
  logic [1:0] fm_hit;

  always_comb begin
    row_ok  = 1'b1;
    fm_hit  = 2'b00;
    bad_len = (col_cnt_q != CW'(WIDTH)) && (lat_cnt_q == 7'd0);
`ifdef HUB75_RX_FM6126_EN
    row_ok  = (lat_cnt_q == 7'd0);
    fm_hit  = {lat_cnt_q == 7'd12, lat_cnt_q == 7'd11};
    if (!row_ok && fm_hit == 2'b00) bad_len = 1'b1;
`endif
  end

  logic col_err_q, panel_on_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_q   <= 1'b0;
      col_err_q  <= 1'b0;
      panel_on_q <= 1'b0;
    end else begin
      commit_q   <= latch_fall && row_ok;
      col_err_q  <= latch_fall && bad_len;
      panel_on_q <= ~s2_q[2];
    end
  end

`ifdef HUB75_RX_FM6126_EN
  logic [15:0] fm_cap;
  logic [15:0] fm_r1_q, fm_r2_q;
  logic [1:0]  fm_wr_q;

  for (gi = 0; gi < 16; gi++) begin : g_fm
    assign fm_cap[gi] = sr_q[WIDTH-1-gi][3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fm_r1_q <= '0;
      fm_r2_q <= '0;
      fm_wr_q <= '0;
    end else begin
      fm_wr_q <= latch_fall ? fm_hit : 2'b00;
      if (latch_fall && fm_hit[0]) fm_r1_q <= fm_cap;
      if (latch_fall && fm_hit[1]) fm_r2_q <= fm_cap;
    end
  end

  assign fm_r1 = fm_r1_q;
  assign fm_r2 = fm_r2_q;
  assign fm_wr = fm_wr_q;
`endif

  logic              pix_valid_q, row_done_q, overrun_q;
  logic [XW-1:0]     pix_x_q, x_next;
  logic [ADDR_W-1:0] pix_row_q;
  logic [5:0]        pix_rgb_q;

  assign x_next = pix_x_q + XW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_row_q   <= '0;
      pix_rgb_q   <= '0;
      row_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      if (commit_q && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // Hold buffer is written this same edge, so beat 0 comes straight from the shifter.
          if (commit_q) begin
            state_q     <= S_EMIT;
            pix_valid_q <= 1'b1;
            pix_x_q     <= '0;
            pix_rgb_q   <= sr_q[0];
            pix_row_q   <= addr_s3_q;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            if (pix_x_q == XW'(WIDTH - 1)) begin
              state_q     <= S_DONE;
              pix_valid_q <= 1'b0;
              row_done_q  <= 1'b1;
            end else begin
              pix_x_q   <= x_next;
              pix_rgb_q <= hold_q[x_next];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_row   = pix_row_q;
  assign pix_rgb0  = pix_rgb_q[5:3];
  assign pix_rgb1  = pix_rgb_q[2:0];
  assign row_done  = row_done_q;
  assign overrun   = overrun_q;
  assign col_err   = col_err_q;
  assign panel_on  = panel_on_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed/randomised bench for hub75_rx; expected rows come from a history of every pushed column.
module tb_hub75_rx;
  localparam int WIDTH = 64;
  localparam int ADDR_W = 5;
  localparam int XW = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        hub_rgb0, hub_rgb1;
  logic [ADDR_W-1:0] hub_addr;
  logic              hub_blank, hub_latch, hub_sclk, pix_ready;
  logic              pix_valid, row_done, overrun, col_err, panel_on;
  logic [XW-1:0]     pix_x;
  logic [ADDR_W-1:0] pix_row;
  logic [2:0]        pix_rgb0, pix_rgb1;
`ifdef HUB75_RX_FM6126_EN
  logic [15:0]       fm_r1, fm_r2;
  logic [1:0]        fm_wr;
`endif

  hub75_rx #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .hub_addr(hub_addr),
    .hub_blank(hub_blank), .hub_latch(hub_latch), .hub_sclk(hub_sclk),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_row(pix_row),
    .pix_rgb0(pix_rgb0), .pix_rgb1(pix_rgb1), .row_done(row_done),
    .overrun(overrun), .col_err(col_err), .panel_on(panel_on)
`ifdef HUB75_RX_FM6126_EN
    , .fm_r1(fm_r1), .fm_r2(fm_r2), .fm_wr(fm_wr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  logic [5:0]        hist[$];
  logic [5:0]        exp_row[WIDTH];
  logic [ADDR_W-1:0] exp_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] r0, input logic [2:0] r1);
    hub_rgb0 = r0;
    hub_rgb1 = r1;
    tick(2);
    hub_sclk = 1'b1;
    tick(3);
    hub_sclk = 1'b0;
    tick(3);
    hist.push_back({r0, r1});
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push(3'($urandom), 3'($urandom));
  endtask

  // Row seen by the panel = the WIDTH most recent pushes, oldest first; never-written slots read 0.
  task automatic snapshot(input logic [ADDR_W-1:0] addr);
    int n;
    n = hist.size();
    for (int x = 0; x < WIDTH; x++) begin
      int idx;
      idx = n - WIDTH + x;
      exp_row[x] = (idx >= 0) ? hist[idx] : 6'd0;
    end
    exp_addr = addr;
  endtask

  task automatic latch_pulse(input int exp_err, input string tag);
    int errs;
    errs = 0;
    pix_ready = 1'b0;
    hub_latch = 1'b1;
    tick(4);
    hub_latch = 1'b0;
    repeat (8) begin
      tick(1);
      if (col_err) errs++;
    end
    check(tag, 64'(errs), 64'(exp_err));
  endtask

  task automatic reset_outs_check(input string tag);
    check(tag, 64'({pix_valid, pix_x, pix_row, pix_rgb0, pix_rgb1, row_done, overrun, col_err, panel_on}), 64'd0);
`ifdef HUB75_RX_FM6126_EN
    check({tag, "_fm"}, 64'({fm_r1, fm_r2, fm_wr}), 64'd0);
`endif
  endtask

  // mode 0: always ready, mode 1: ready one cycle in three.
  // inject_kind 1: second latch at beat inject_at; 2: reset at beat inject_at.
  task automatic recv(input int mode, input int inject_at, input int inject_kind, input string tag);
    int beats, cyc;
    bit held, injected, aborted, rdy;
    logic [11:0] held_v, cur;
    beats = 0; cyc = 0; held = 0; injected = 0; aborted = 0; held_v = '0;
    pix_ready = 1'b0;
    while (beats < WIDTH && cyc < 3000 && !aborted) begin
      tick(1);
      cyc++;
      if (pix_valid) begin
        cur = {pix_x, pix_rgb0, pix_rgb1};
        if (held) check({tag, "_held"}, 64'(cur), 64'(held_v));
        if (!injected && inject_kind != 0 && beats == inject_at) begin
          injected = 1;
          pix_ready = 1'b0;
          if (inject_kind == 1) begin
            push_random(5);
            latch_pulse(1, {tag, "_drop_colerr"});
            held = 1;
            held_v = cur;
          end else begin
            reset = 1'b1;
            tick(1);
            reset_outs_check({tag, "_reset"});
            reset = 1'b0;
            hist.delete();
            aborted = 1;
          end
        end else begin
          rdy = (mode == 0) || (cyc % 3 == 0);
          pix_ready = rdy;
          if (rdy) begin
            check($sformatf("%s_beat%0d", tag, beats),
                  64'({pix_x, pix_rgb0, pix_rgb1, pix_row}),
                  64'({XW'(beats), exp_row[beats], exp_addr}));
            beats++;
            held = 0;
          end else begin
            held = 1;
            held_v = cur;
          end
        end
      end
    end
    if (!aborted) begin
      check({tag, "_beats"}, 64'(beats), 64'(WIDTH));
      tick(1);
      pix_ready = 1'b0;
      check({tag, "_rowdone"}, 64'({row_done, pix_valid}), 64'(2'b10));
      tick(1);
      check({tag, "_rowdone_end"}, 64'(row_done), 64'd0);
    end
  endtask

`ifdef HUB75_RX_FM6126_EN
  task automatic fm_load(input logic [15:0] pat, input int nlat, input logic [1:0] exp_wr, input string tag);
    logic [1:0] wrs;
    int vld, errs;
    wrs = 2'b00; vld = 0; errs = 0;
    pix_ready = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - nlat) begin
        hub_latch = 1'b1;
        tick(2);
      end
      push({2'($urandom), pat[15 - (i % 16)]}, 3'($urandom));
    end
    hub_latch = 1'b0;
    repeat (12) begin
      tick(1);
      wrs = wrs | fm_wr;
      if (pix_valid) vld++;
      if (col_err) errs++;
    end
    check({tag, "_wr"}, 64'(wrs), 64'(exp_wr));
    check({tag, "_novalid"}, 64'(vld), 64'd0);
    check({tag, "_nocolerr"}, 64'(errs), 64'd0);
  endtask
`endif

  initial begin
    int vcount;
    logic [ADDR_W-1:0] a;
    reset = 1'b1;
    hub_rgb0 = '0; hub_rgb1 = '0; hub_addr = '0;
    hub_blank = 1'b0; hub_latch = 1'b0; hub_sclk = 1'b0; pix_ready = 1'b0;
    tick(3);
    reset_outs_check("por");
    reset = 1'b0;
    tick(4);
    check("panel_on_unblanked", 64'(panel_on), 64'd1);
    hub_blank = 1'b1;
    tick(4);
    check("panel_on_blanked", 64'(panel_on), 64'd0);
    hub_blank = 1'b0;

    // Ramp row at address 7, free-running ready.
    hub_addr = 5'd7;
    for (int x = 0; x < WIDTH; x++) begin
      logic [2:0] xv;
      xv = 3'(x);
      push(xv, ~xv);
    end
    snapshot(5'd7);
    latch_pulse(0, "t1_colerr");
    recv(0, -1, 0, "t1");

    // Random full row, throttled ready.
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH);
    snapshot(a);
    latch_pulse(0, "t2_colerr");
    recv(1, -1, 0, "t2");

    // Short row: length error, stream still emits WIDTH beats.
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH - 1);
    snapshot(a);
    latch_pulse(1, "t4_colerr");
    recv(0, -1, 0, "t4");
    check("t4_no_overrun", 64'(overrun), 64'd0);

    // Second latch while beat 10 is pending: dropped, overrun sticks.
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH);
    snapshot(a);
    latch_pulse(0, "t3_colerr");
    hub_addr = ~a;
    recv(0, 10, 1, "t3");
    vcount = 0;
    repeat (40) begin
      tick(1);
      if (pix_valid) vcount++;
    end
    check("t3_no_second_stream", 64'(vcount), 64'd0);
    check("t3_overrun", 64'(overrun), 64'd1);

`ifdef HUB75_RX_FM6126_EN
    fm_load(16'h7FFF, 11, 2'b01, "fm1");
    check("fm_r1", 64'(fm_r1), 64'h7FFF);
    fm_load(16'h0040, 12, 2'b10, "fm2");
    check("fm_r2", 64'(fm_r2), 64'h0040);
    check("fm_r1_kept", 64'(fm_r1), 64'h7FFF);
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH);
    snapshot(a);
    latch_pulse(0, "fm_row_colerr");
    recv(0, -1, 0, "fm_row");
`endif

    // Reset at beat 20, then a fresh row from x=0.
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH);
    snapshot(a);
    latch_pulse(0, "t6_colerr");
    recv(0, 20, 2, "t6");
    tick(4);
    check("t6_overrun_cleared", 64'(overrun), 64'd0);
    a = 5'($urandom);
    hub_addr = a;
    push_random(WIDTH);
    snapshot(a);
    latch_pulse(0, "t7_colerr");
    recv(1, -1, 0, "t7");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
